current_update: RTL and testbench

CURRENT_UPDATE -- requirements
Module: current_update

---
 rtl/current_update.sv | 110 +++++++++++
 tb/tb_current_update.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/current_update.sv
// current_update: double-buffered neuron current store.
// Two banks of DEPTH x DATA_W words; a bank-select bit picks the "current"
// bank (read-only) and the other is the "next" bank (written during a timestep).
// swap toggles the select and clears the bank that becomes next.
// Optional feature: define CURRENT_UPDATE_ACCUM_EN to make next-bank writes
// saturating signed accumulates instead of overwrites.
module current_update #(
   parameter int unsigned TAG_W  = 1,
   parameter int unsigned DATA_W = 17
) (
   input  logic              clk,
   input  logic              asyn_reset,
   input  logic              swap,
   input  logic              i_next_write_en,
   input  logic [TAG_W-1:0]  i_next_write_tag,
   input  logic [DATA_W-1:0] i_next_write_value,
   input  logic [TAG_W-1:0]  i_read_tag,
   input  logic [TAG_W-1:0]  i_next_read_tag,
   output logic [DATA_W-1:0] i_read_value,
   output logic [DATA_W-1:0] i_next_read_value
);

   localparam int unsigned DEPTH = 2**TAG_W;

   typedef logic [DATA_W-1:0] word_t;

   word_t bank0_q [DEPTH];
   word_t bank1_q [DEPTH];
   word_t bank0_d [DEPTH];
   word_t bank1_d [DEPTH];
   logic  sel_q;
   logic  sel_d;
   word_t next_old;
   word_t next_new;

`ifdef CURRENT_UPDATE_ACCUM_EN
   localparam word_t SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
   localparam word_t SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

   // Signed add with clamping to the most positive / most negative word.
   function automatic word_t sat_add(input word_t a, input word_t b);
      logic [DATA_W:0] s;
      s = {a[DATA_W-1], a} + {b[DATA_W-1], b};
      if (s[DATA_W] != s[DATA_W-1]) begin
         return s[DATA_W] ? SAT_MIN : SAT_MAX;
      end
      return s[DATA_W-1:0];
   endfunction
`endif

   // Combinational reads: sel_q=0 means bank0 is current, bank1 is next.
   always_comb begin
      i_read_value      = '0;
      i_next_read_value = '0;
      if (sel_q) begin
         i_read_value      = bank1_q[i_read_tag];
         i_next_read_value = bank0_q[i_next_read_tag];
      end else begin
         i_read_value      = bank0_q[i_read_tag];
         i_next_read_value = bank1_q[i_next_read_tag];
      end
   end

   // Value to be stored into the addressed next-bank entry.
   always_comb begin
      next_old = sel_q ? bank0_q[i_next_write_tag] : bank1_q[i_next_write_tag];
`ifdef CURRENT_UPDATE_ACCUM_EN
      next_new = sat_add(next_old, i_next_write_value);
`else
      next_new = i_next_write_value;
`endif
   end

   // Next-state: write lands in the pre-swap next bank, then swap clears the
   // old current bank, so a same-edge write ends up visible as current.
   always_comb begin
      bank0_d = bank0_q;
      bank1_d = bank1_q;
      sel_d   = sel_q;
      if (i_next_write_en) begin
         if (sel_q) bank0_d[i_next_write_tag] = next_new;
         else       bank1_d[i_next_write_tag] = next_new;
      end
      if (swap) begin
         sel_d = ~sel_q;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            if (sel_q) bank1_d[i] = '0;
            else       bank0_d[i] = '0;
         end
      end
   end

   // State registers with asynchronous clear of both banks and the select.
   always_ff @(posedge clk or posedge asyn_reset) begin
      if (asyn_reset) begin
         sel_q <= 1'b0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            bank0_q[i] <= '0;
            bank1_q[i] <= '0;
         end
      end else begin
         sel_q <= sel_d;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            bank0_q[i] <= bank0_d[i];
            bank1_q[i] <= bank1_d[i];
         end
      end
   end

endmodule

// File: tb/tb_current_update.sv
// Directed testbench for current_update (TAG_W=1, DATA_W=17).
// Expected values are hand-computed; accumulate-mode expectations are
// selected with CURRENT_UPDATE_ACCUM_EN.
module tb_current_update;

   localparam int unsigned TAG_W  = 1;
   localparam int unsigned DATA_W = 17;

   logic              clk = 1'b0;
   logic              asyn_reset;
   logic              swap;
   logic              i_next_write_en;
   logic [TAG_W-1:0]  i_next_write_tag;
   logic [DATA_W-1:0] i_next_write_value;
   logic [TAG_W-1:0]  i_read_tag;
   logic [TAG_W-1:0]  i_next_read_tag;
   logic [DATA_W-1:0] i_read_value;
   logic [DATA_W-1:0] i_next_read_value;

   int n_assert = 0;
   int n_fail   = 0;

   current_update #(.TAG_W(TAG_W), .DATA_W(DATA_W)) dut (
      .clk                (clk),
      .asyn_reset         (asyn_reset),
      .swap               (swap),
      .i_next_write_en    (i_next_write_en),
      .i_next_write_tag   (i_next_write_tag),
      .i_next_write_value (i_next_write_value),
      .i_read_tag         (i_read_tag),
      .i_next_read_tag    (i_next_read_tag),
      .i_read_value       (i_read_value),
      .i_next_read_value  (i_next_read_value)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [DATA_W-1:0] obs,
                        input logic [DATA_W-1:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%05h expected=%05h", tag, obs, exp);
      end
   endtask

   // Check current and next value at tag t.
   task automatic check_tag(input string tag, input logic [TAG_W-1:0] t,
                            input logic [DATA_W-1:0] exp_cur,
                            input logic [DATA_W-1:0] exp_next);
      i_read_tag      = t;
      i_next_read_tag = t;
      #1;
      check({tag, "_cur"}, i_read_value, exp_cur);
      check({tag, "_next"}, i_next_read_value, exp_next);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write(input logic [TAG_W-1:0] t, input logic [DATA_W-1:0] v,
                        input logic sw);
      i_next_write_en    = 1'b1;
      i_next_write_tag   = t;
      i_next_write_value = v;
      swap               = sw;
      tick();
      i_next_write_en    = 1'b0;
      swap               = 1'b0;
   endtask

   initial begin
      asyn_reset         = 1'b1;
      swap               = 1'b0;
      i_next_write_en    = 1'b0;
      i_next_write_tag   = '0;
      i_next_write_value = '0;
      i_read_tag         = '0;
      i_next_read_tag    = '0;
      tick();
      check_tag("reset_t0", 1'b0, 17'h00000, 17'h00000);
      check_tag("reset_t1", 1'b1, 17'h00000, 17'h00000);
      asyn_reset = 1'b0;
      tick();

      // Write both tags, then swap.
      write(1'b0, 17'h08000, 1'b0);
      write(1'b1, 17'h04000, 1'b0);
      check_tag("prewr_t0", 1'b0, 17'h00000, 17'h08000);
      check_tag("prewr_t1", 1'b1, 17'h00000, 17'h04000);
      swap = 1'b1;
      tick();
      swap = 1'b0;
      check_tag("swap1_t0", 1'b0, 17'h08000, 17'h00000);
      check_tag("swap1_t1", 1'b1, 17'h04000, 17'h00000);

      // Second swap with no writes.
      swap = 1'b1;
      tick();
      swap = 1'b0;
      check_tag("swap2_t0", 1'b0, 17'h00000, 17'h00000);
      check_tag("swap2_t1", 1'b1, 17'h00000, 17'h00000);

      // Write/swap collision.
      write(1'b1, 17'h00123, 1'b1);
      check_tag("coll_t1", 1'b1, 17'h00123, 17'h00000);
      check_tag("coll_t0", 1'b0, 17'h00000, 17'h00000);

      // Read during write: old value until the edge.
      write(1'b0, 17'h00010, 1'b0);
      i_next_write_en    = 1'b1;
      i_next_write_tag   = 1'b0;
      i_next_write_value = 17'h00020;
      i_next_read_tag    = 1'b0;
      #1;
      check("rdw_before", i_next_read_value, 17'h00010);
      tick();
      i_next_write_en = 1'b0;
`ifdef CURRENT_UPDATE_ACCUM_EN
      check_tag("rdw_after", 1'b0, 17'h00000, 17'h00030);
`else
      check_tag("rdw_after", 1'b0, 17'h00000, 17'h00020);
`endif

      // Disabled write leaves next bank and current bank untouched.
      i_next_write_tag   = 1'b0;
      i_next_write_value = 17'h1ABCD;
      tick();
`ifdef CURRENT_UPDATE_ACCUM_EN
      check_tag("nowr_t0", 1'b0, 17'h00000, 17'h00030);
`else
      check_tag("nowr_t0", 1'b0, 17'h00000, 17'h00020);
`endif
      check_tag("cur_hold_t1", 1'b1, 17'h00123, 17'h00000);

      // Reset asserted mid-cycle clears everything immediately.
      #3;
      asyn_reset = 1'b1;
      i_read_tag = 1'b1;
      #1;
      check("rst_mid_cur", i_read_value, 17'h00000);
      i_next_read_tag = 1'b0;
      #1;
      check("rst_mid_next", i_next_read_value, 17'h00000);
      // swap and write are ignored while reset is held.
      i_next_write_en    = 1'b1;
      i_next_write_value = 17'h00777;
      swap               = 1'b1;
      tick();
      check_tag("rst_hold_t0", 1'b0, 17'h00000, 17'h00000);
      check_tag("rst_hold_t1", 1'b1, 17'h00000, 17'h00000);
      i_next_write_en = 1'b0;
      swap            = 1'b0;
      asyn_reset      = 1'b0;
      tick();
      check_tag("post_rst_t0", 1'b0, 17'h00000, 17'h00000);

      // Repeated-write behaviour (saturating accumulate vs overwrite).
      write(1'b0, 17'h0F000, 1'b0);
      write(1'b0, 17'h0F000, 1'b0);
      write(1'b1, 17'h1FFFF, 1'b0);
      write(1'b1, 17'h1FFFF, 1'b0);
`ifdef CURRENT_UPDATE_ACCUM_EN
      check_tag("acc_pos_sat", 1'b0, 17'h00000, 17'h0FFFF);
      check_tag("acc_neg1x2", 1'b1, 17'h00000, 17'h1FFFE);
      // Accumulate on a swap edge lands in the bank becoming current.
      write(1'b1, 17'h00003, 1'b1);
      check_tag("acc_swap_t1", 1'b1, 17'h00001, 17'h00000);
      check_tag("acc_swap_t0", 1'b0, 17'h0FFFF, 17'h00000);
      write(1'b0, 17'h10000, 1'b0);
      write(1'b0, 17'h10000, 1'b0);
      check_tag("acc_neg_sat", 1'b0, 17'h0FFFF, 17'h10000);
`else
      check_tag("ovw_t0", 1'b0, 17'h00000, 17'h0F000);
      check_tag("ovw_t1", 1'b1, 17'h00000, 17'h1FFFF);
      write(1'b0, 17'h00005, 1'b0);
      check_tag("ovw_t0b", 1'b0, 17'h00000, 17'h00005);
      write(1'b1, 17'h00003, 1'b1);
      check_tag("ovw_swap_t1", 1'b1, 17'h00003, 17'h00000);
      check_tag("ovw_swap_t0", 1'b0, 17'h00005, 17'h00000);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
